loop_sensor_conditioner: RTL

- Upstream stage of the adaptive traffic_light controller.
- Takes two raw, bouncy inductive-loop detector inputs (north, east) and debounces them.
- Applies a minimum presence hold and detects stuck-high detectors.
- Drives clean sensor_north/sensor_east straight into the controller, and keeps saturating per-direction vehicle counts for the config/monitor path.

---
 rtl/loop_sensor_conditioner.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/loop_sensor_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : loop_sensor_conditioner
//  Purpose  : Debounces two raw inductive-loop detectors (north, east).
//             Applies a minimum presence hold and flags stuck-high detectors.
//             Keeps saturating per-direction vehicle arrival counts.
//  Revision : 1.0  initial release
// ============================================================================
module loop_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int STUCK_CYCLES    = 64,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 raw_north,
  input  logic                 raw_east,
  input  logic                 clear_counts,
  output logic                 sensor_north,
  output logic                 sensor_east,
  output logic                 fault_north,
  output logic                 fault_east,
  output logic [CNT_WIDTH-1:0] count_north,
  output logic [CNT_WIDTH-1:0] count_east
);

  // Terminal values of the run and stuck counters. The counter value that
  // triggers a transition is one less than the number of qualifying edges,
  // because the edge that enters the state already counts as the first one.
  localparam logic [7:0]  DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_CYCLES - 1);
  localparam logic [15:0] STUCK_LAST = 16'(STUCK_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  // Channel 0 is north, channel 1 is east.
  logic                 raw_w    [2];
  logic                 sensor_w [2];
  logic                 fault_w  [2];
  logic [CNT_WIDTH-1:0] count_w  [2];

  assign raw_w[0] = raw_north;
  assign raw_w[1] = raw_east;

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic                 sync1_q, sync2_q;
    state_e               state_q, state_d;
    logic [7:0]           run_q, run_d;
    logic [15:0]          stuck_q, stuck_d;
    logic                 inc_w;
    logic                 sensor_q, fault_q;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    // Two-flop synchroniser for the asynchronous detector input.
    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= raw_w[ch];
        sync2_q <= sync1_q;
      end
    end

    // Channel FSM next-state logic: debounce, presence hold, stuck detection.
    always_comb begin
      state_d = state_q;
      run_d   = run_q;
      stuck_d = stuck_q;
      inc_w   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sync2_q) begin
            state_d = ST_ARM;
            run_d   = 8'd1;
          end
        end
        ST_ARM: begin
          if (!sync2_q) begin
            state_d = ST_IDLE;
          end else if (run_q == DEB_LAST) begin
            state_d = ST_ACTIVE;
            stuck_d = 16'd1;
            inc_w   = 1'b1;
          end else begin
            run_d = run_q + 8'd1;
          end
        end
        ST_ACTIVE: begin
          if (!sync2_q) begin
            state_d = ST_HOLD;
            run_d   = 8'd1;
          end else if (stuck_q == STUCK_LAST) begin
            state_d = ST_FAULT;
            run_d   = 8'd0;
          end else begin
            stuck_d = stuck_q + 16'd1;
          end
        end
        ST_HOLD: begin
          // A return to high during the hold is the same vehicle: no count.
          if (sync2_q) begin
            state_d = ST_ACTIVE;
            stuck_d = 16'd1;
          end else if (run_q == HOLD_LAST) begin
            state_d = ST_IDLE;
          end else begin
            run_d = run_q + 8'd1;
          end
        end
        ST_FAULT: begin
          // Leave only after a clean run of low samples; any high restarts it.
          if (sync2_q) begin
            run_d = 8'd0;
          end else if (run_q == DEB_LAST) begin
            state_d = ST_IDLE;
          end else begin
            run_d = run_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Saturating vehicle counter; a clear coincident with an arrival keeps it.
    always_comb begin
      count_d = count_q;
      if (clear_counts) begin
        count_d = inc_w ? CNT_WIDTH'(1) : '0;
      end else if (inc_w && (count_q != '1)) begin
        count_d = count_q + CNT_WIDTH'(1);
      end
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= ST_IDLE;
        run_q    <= 8'd0;
        stuck_q  <= 16'd0;
        count_q  <= '0;
        sensor_q <= 1'b0;
        fault_q  <= 1'b0;
      end else begin
        state_q  <= state_d;
        run_q    <= run_d;
        stuck_q  <= stuck_d;
        count_q  <= count_d;
        sensor_q <= (state_d == ST_ACTIVE) || (state_d == ST_HOLD);
        fault_q  <= (state_d == ST_FAULT);
      end
    end

    assign sensor_w[ch] = sensor_q;
    assign fault_w[ch]  = fault_q;
    assign count_w[ch]  = count_q;
  end

  assign sensor_north = sensor_w[0];
  assign sensor_east  = sensor_w[1];
  assign fault_north  = fault_w[0];
  assign fault_east   = fault_w[1];
  assign count_north  = count_w[0];
  assign count_east   = count_w[1];

endmodule
`default_nettype wire
